// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - scrolling pipe obstacles, score and bird collision for flappy-bird
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   restart    synchronous pulse, returns the field to IDLE
//   bird_y     bird sprite top y (pixels)
//   alive      bird is in play
//   collision  registered: bird box overlaps a pipe body
//   score      pipes passed, saturating at 999
//   pipe_x     three 12-bit signed pipe left edges, pipe 0 in [11:0]
//   gap_y      three 10-bit gap tops, pipe 0 in [9:0]
module pipe_field #(
  parameter int SCREEN_W     = 640,
  parameter int PIPE_W       = 52,
  parameter int PIPE_SPACING = 220,
  parameter int GAP_H        = 140,
  parameter int GAP_TOP_MIN  = 80,
  parameter int GAP_INIT     = 180,
  parameter int BIRD_X       = 100,
  parameter int SPRITE_W     = 34,
  parameter int SPRITE_H     = 24,
  parameter int SCROLL_SPEED = 2,
  parameter int TICK_BITS    = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic [9:0]  bird_y,
  input  logic        alive,
  output logic        collision,
  output logic [9:0]  score,
  output logic [35:0] pipe_x,
  output logic [29:0] gap_y
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic signed [11:0] PW_S    = 12'(PIPE_W);
  localparam logic signed [11:0] BX_S    = 12'(BIRD_X);
  localparam logic signed [11:0] BXR_S   = 12'(BIRD_X + SPRITE_W);
  localparam logic signed [11:0] SH_S    = 12'(SPRITE_H);
  localparam logic signed [11:0] GH_S    = 12'(GAP_H);
  localparam logic signed [11:0] SPD_S   = 12'(SCROLL_SPEED);
  localparam logic signed [11:0] WRAP_S  = 12'(3 * PIPE_SPACING);
  localparam logic signed [11:0] ZERO_S  = 12'sd0;
  localparam logic [9:0]         GMIN    = 10'(GAP_TOP_MIN);
  localparam logic [9:0]         GINIT   = 10'(GAP_INIT);
  localparam logic [9:0]         SCORE_MAX = 10'd999;

  state_t state, state_nxt;

  logic [TICK_BITS-1:0] tick;
  logic [15:0]          lfsr;
  logic signed [11:0]   x_q [0:2];
  logic [9:0]           g_q [0:2];

  logic signed [11:0]   x_dec   [0:2];
  logic signed [11:0]   x_nxt   [0:2];
  logic [2:0]           respawn;
  logic [2:0]           passed;
  logic [2:0]           hit;
  logic signed [11:0]   by_s;
  logic signed [11:0]   gy_s;
  logic                 h_ovl;
  logic                 v_miss;
  logic [9:0]           gap_new;

  // Fibonacci LFSR, taps 16,14,13,11 shifted in at the bottom.
  logic lfsr_fb;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  assign gap_new = GMIN + {3'b000, lfsr[7:1]};

  always_comb begin
    by_s   = $signed({2'b00, bird_y});
    gy_s   = 12'sd0;
    h_ovl  = 1'b0;
    v_miss = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_dec[i]   = x_q[i] - SPD_S;
      // A pipe whose right edge has scrolled to or past x=0 wraps behind the last one.
      respawn[i] = (x_dec[i] + PW_S) <= ZERO_S;
      x_nxt[i]   = respawn[i] ? (x_dec[i] + WRAP_S) : x_dec[i];
      // Right edge crosses the bird's left edge on this step.
      passed[i]  = ((x_q[i] + PW_S) > BX_S) && ((x_dec[i] + PW_S) <= BX_S);
      gy_s       = $signed({2'b00, g_q[i]});
      h_ovl      = (x_q[i] < BXR_S) && ((x_q[i] + PW_S) > BX_S);
      v_miss     = (by_s < gy_s) || ((by_s + SH_S) > (gy_s + GH_S));
      hit[i]     = h_ovl && v_miss;
    end
  end

  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (alive)  state_nxt = RUN;
        RUN:     if (!alive) state_nxt = HALT;
        HALT:    state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Tick counter and LFSR run in every state; restart leaves them alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick <= '0;
      lfsr <= 16'hACE1;
    end else begin
      tick <= tick + TICK_BITS'(1);
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= 12'(SCREEN_W + i * PIPE_SPACING);
        g_q[i] <= GINIT;
      end
      score     <= '0;
      collision <= 1'b0;
    end else if (restart || state == IDLE) begin
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= 12'(SCREEN_W + i * PIPE_SPACING);
        g_q[i] <= GINIT;
      end
      score     <= '0;
      collision <= 1'b0;
    end else if (state == RUN && alive) begin
      collision <= |hit;
      if (tick == '0) begin
        for (int i = 0; i < 3; i++) begin
          x_q[i] <= x_nxt[i];
          if (respawn[i]) g_q[i] <= gap_new;
        end
        if (|passed && score != SCORE_MAX) score <= score + 10'd1;
      end
    end
    // HALT, and the RUN cycle where alive drops, hold everything.
  end

  assign pipe_x = {x_q[2], x_q[1], x_q[0]};
  assign gap_y  = {g_q[2], g_q[1], g_q[0]};

endmodule

// File: tb/tb_pipe_field.sv
// tb/tb_pipe_field.sv - directed self-checking bench for pipe_field
module tb_pipe_field;

  logic        clk;
  logic        reset_n;
  logic        restart;
  logic [9:0]  bird_y;
  logic        alive;
  logic        collision;
  logic [9:0]  score;
  logic [35:0] pipe_x;
  logic [29:0] gap_y;

  int n_cmp  = 0;
  int n_fail = 0;

  // Bench-side reference state.
  logic [15:0] m_lfsr;
  logic [15:0] tick_lfsr;
  int          edge_idx;
  int          tick_count;
  bit          m_running;

  logic [35:0] x_init;
  logic [29:0] g_init;
  logic [9:0]  exp_gap;

  pipe_field #(.TICK_BITS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (restart),
    .bird_y    (bird_y),
    .alive     (alive),
    .collision (collision),
    .score     (score),
    .pipe_x    (pipe_x),
    .gap_y     (gap_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; tracks tick edges (tick counter period 16) and the LFSR value used there.
  task automatic cyc();
    @(posedge clk);
    if ((edge_idx % 16) == 0 && m_running) begin
      tick_count++;
      tick_lfsr = m_lfsr;
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    edge_idx++;
    #1;
  endtask

  task automatic run_to(input int target);
    while (tick_count < target) cyc();
  endtask

  initial begin
    x_init     = {12'd1080, 12'd860, 12'd640};
    g_init     = {10'd180, 10'd180, 10'd180};
    reset_n    = 1'b0;
    restart    = 1'b0;
    alive      = 1'b0;
    bird_y     = 10'd200;
    m_running  = 1'b0;
    tick_count = 0;
    tick_lfsr  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    m_lfsr   = 16'hACE1;
    edge_idx = 0;

    // Reset values
    check("rst_pipe_x", pipe_x, x_init);
    check("rst_gap_y", gap_y, g_init);
    check("rst_score", score, 0);
    check("rst_collision", collision, 0);

    // Idle with alive low: nothing moves
    repeat (100) cyc();
    check("idle_pipe_x", pipe_x, x_init);
    check("idle_score", score, 0);

    // Start running
    alive = 1'b1;
    cyc();
    m_running  = 1'b1;
    tick_count = 0;
    run_to(5);
    check("tick5_pipe_x", pipe_x, {12'd1070, 12'd850, 12'd630});
    check("tick5_collision", collision, 0);

    // Pipe 0 overlapping the bird, bird inside gap
    run_to(280);
    check("tick280_pipe_x", pipe_x, {12'd520, 12'd300, 12'd80});
    check("tick280_collision_in_gap", collision, 0);
    bird_y = 10'd100;
    check("collision_latency", collision, 0);
    cyc();
    check("collision_above_gap", collision, 1);
    bird_y = 10'd200;
    cyc();
    check("collision_cleared", collision, 0);

    // Score crossing
    run_to(295);
    check("tick295_pipe0", pipe_x[11:0], 12'd50);
    check("tick295_score", score, 0);
    run_to(296);
    check("tick296_pipe0", pipe_x[11:0], 12'd48);
    check("tick296_score", score, 1);
    run_to(300);
    check("tick300_pipe0", pipe_x[11:0], 12'd40);
    check("tick300_score", score, 1);

    // Respawn of pipe 0
    run_to(345);
    check("tick345_pipe_x", pipe_x, {12'd390, 12'd170, 12'hFCE});
    run_to(346);
    exp_gap = 10'd80 + {3'b000, tick_lfsr[7:1]};
    check("respawn_pipe_x", pipe_x, {12'd388, 12'd168, 12'd608});
    check("respawn_gap_y", gap_y, {10'd180, 10'd180, exp_gap});
    check("respawn_gap_range", (gap_y[9:0] >= 10'd80 && gap_y[9:0] <= 10'd207), 1);
    check("respawn_score", score, 1);

    // Collision with pipe 1, then halt
    bird_y = 10'd100;
    run_to(363);
    cyc();
    check("tick363_collision", collision, 0);
    run_to(364);
    check("tick364_pipe_x", pipe_x, {12'd352, 12'd132, 12'd572});
    check("tick364_collision_latency", collision, 0);
    cyc();
    check("tick364_collision", collision, 1);
    alive     = 1'b0;
    m_running = 1'b0;
    cyc();
    repeat (160) cyc();
    check("halt_pipe_x", pipe_x, {12'd352, 12'd132, 12'd572});
    check("halt_collision", collision, 1);
    check("halt_score", score, 1);

    // Restart pulse
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("restart_pipe_x", pipe_x, x_init);
    check("restart_gap_y", gap_y, g_init);
    check("restart_score", score, 0);
    check("restart_collision", collision, 0);

    // Restart wins over alive
    bird_y = 10'd200;
    alive  = 1'b1;
    cyc();
    m_running  = 1'b1;
    tick_count = 0;
    run_to(3);
    check("rerun_pipe_x", pipe_x, {12'd1074, 12'd854, 12'd634});
    restart   = 1'b1;
    m_running = 1'b0;
    cyc();
    restart = 1'b0;
    check("restart_alive_pipe_x", pipe_x, x_init);
    check("restart_alive_score", score, 0);
    cyc();
    m_running  = 1'b1;
    tick_count = 0;
    run_to(2);
    check("run2_pipe_x", pipe_x, {12'd1076, 12'd856, 12'd636});

    // Asynchronous reset between clock edges
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pipe_x", pipe_x, x_init);
    check("async_rst_gap_y", gap_y, g_init);
    check("async_rst_score", score, 0);
    check("async_rst_collision", collision, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
